// File: rtl/spi_flash_pkg.sv
// +--------------------------------------------------------------------------+
// | spi_flash_pkg : shared types/constants for the SPI flash burst reader     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package spi_flash_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_CS_SETUP = 3'd1,
      ST_CMD      = 3'd2,
      ST_ADDR     = 3'd3,
      ST_DUMMY    = 3'd4,
      ST_DATA     = 3'd5,
      ST_CS_HOLD  = 3'd6,
      ST_DONE     = 3'd7
   } state_t;

   localparam logic [7:0] OP_READ  = 8'h03;
   localparam logic [7:0] OP_FAST  = 8'h0B;

   // Mode 0: SCK idles low, MOSI changes on falling edges, MISO sampled on rising edges.
   localparam logic       SCK_IDLE = 1'b0;

   localparam int         TX_W     = 40;

   function automatic logic cs_active(input state_t s);
      return (s inside {ST_CS_SETUP, ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA});
   endfunction

endpackage

`default_nettype wire

// File: rtl/spi_sck_gen.sv
// +--------------------------------------------------------------------------+
// | spi_sck_gen : SCK phase counter with run/freeze and rise/fall strobes     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module spi_sck_gen
   import spi_flash_pkg::*;
#(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   output logic sck,
   output logic rise_en,
   output logic fall_en
);

   logic [7:0] phase_cnt;
   logic       phase_end;

   assign phase_end = run && (phase_cnt == 8'(CLK_DIV - 1));
   assign rise_en   = phase_end && (sck == SCK_IDLE);
   assign fall_en   = phase_end && (sck != SCK_IDLE);

   // Dropping run parks SCK low and restarts the phase, so resuming gives a full low phase.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase_cnt <= '0;
         sck       <= SCK_IDLE;
      end else if (!run) begin
         phase_cnt <= '0;
         sck       <= SCK_IDLE;
      end else if (phase_end) begin
         phase_cnt <= '0;
         sck       <= ~sck;
      end else begin
         phase_cnt <= phase_cnt + 8'd1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/spi_flash_burst_reader.sv
// +--------------------------------------------------------------------------+
// | spi_flash_burst_reader : SPI mode-0 burst reader for serial NOR flash     |
// | Optional macro FAST_READ_EN selects FAST_READ opcode + 8 dummy clocks.    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module spi_flash_burst_reader
   import spi_flash_pkg::*;
#(
   parameter int         CLK_DIV   = 2,
   parameter int         ADDR_BITS = 24,
   parameter int         LEN_BITS  = 16,
   parameter logic [7:0] CMD_READ  = OP_READ,
   parameter logic [7:0] CMD_FAST  = OP_FAST
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [ADDR_BITS-1:0] start_addr,
   input  logic [LEN_BITS-1:0]  byte_count,
   output logic                 busy,
   output logic                 done,
   output logic [7:0]           rd_data,
   output logic                 rd_valid,
   input  logic                 rd_ready,
   output logic                 spi_cs_n,
   output logic                 spi_sck,
   output logic                 spi_mosi,
   input  logic                 spi_miso
);

`ifdef FAST_READ_EN
   localparam bit FAST_SEL = 1'b1;
`else
   localparam bit FAST_SEL = 1'b0;
`endif

   localparam logic [7:0] OPCODE = FAST_SEL ? CMD_FAST : CMD_READ;

   state_t              state, state_nx;
   logic [TX_W-1:0]     tx_sr;
   logic [6:0]          rx_sr;
   logic [5:0]          bit_cnt;
   logic [LEN_BITS-1:0] remaining;
   logic [7:0]          hold_cnt;
   logic                done_pulse;
   logic                sck_run;
   logic                rise_en;
   logic                fall_en;
   logic [31:0]         addr_msb;

   // Address left-justified in 32 bits so a 24-bit address still leaves the TX MSB first.
   assign addr_msb = 32'(start_addr) << (32 - ADDR_BITS);

   spi_sck_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sck_gen (
      .clk     (clk),
      .reset   (reset),
      .run     (sck_run),
      .sck     (spi_sck),
      .rise_en (rise_en),
      .fall_en (fall_en)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      sck_run  = 1'b0;
      spi_cs_n = 1'b1;
      spi_mosi = 1'b0;
      busy     = (state != ST_IDLE);

      case (state)
         ST_IDLE:     if (start) state_nx = (byte_count == '0) ? ST_DONE : ST_CS_SETUP;
         ST_CS_SETUP: if (rise_en) state_nx = ST_CMD;
         ST_CMD:      if (fall_en && bit_cnt == 6'd7) state_nx = ST_ADDR;
         ST_ADDR:     if (fall_en && bit_cnt == 6'(ADDR_BITS - 1))
                         state_nx = FAST_SEL ? ST_DUMMY : ST_DATA;
         ST_DUMMY:    if (fall_en && bit_cnt == 6'd7) state_nx = ST_DATA;
         ST_DATA:     if (fall_en && bit_cnt == 6'd7 && remaining == LEN_BITS'(1))
                         state_nx = ST_CS_HOLD;
         ST_CS_HOLD:  if (hold_cnt == 8'(CLK_DIV - 1)) state_nx = ST_DONE;
         ST_DONE:     if (!rd_valid || rd_ready) state_nx = ST_IDLE;
         default:     state_nx = ST_IDLE;
      endcase

      if (cs_active(state)) begin
         spi_cs_n = 1'b0;
         // Hold SCK low at a byte boundary while the previous byte is still unclaimed.
         sck_run  = !(state == ST_DATA && bit_cnt == 6'd0 && spi_sck == SCK_IDLE && rd_valid);
      end

      if (state inside {ST_CS_SETUP, ST_CMD, ST_ADDR}) spi_mosi = tx_sr[TX_W-1];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_sr      <= '0;
         rx_sr      <= '0;
         bit_cnt    <= '0;
         remaining  <= '0;
         hold_cnt   <= '0;
         done_pulse <= 1'b0;
         rd_data    <= '0;
         rd_valid   <= 1'b0;
      end else begin
         done_pulse <= (state == ST_DONE) && (state_nx == ST_IDLE);

         if (state == ST_IDLE && start) begin
            tx_sr     <= {OPCODE, addr_msb};
            remaining <= byte_count;
         end else begin
            if (fall_en) tx_sr <= tx_sr << 1;
            if (state == ST_DATA && fall_en && bit_cnt == 6'd7)
               remaining <= remaining - LEN_BITS'(1);
         end

         if (state != state_nx)
            bit_cnt <= '0;
         else if (fall_en)
            bit_cnt <= (state == ST_DATA && bit_cnt == 6'd7) ? 6'd0 : bit_cnt + 6'd1;

         hold_cnt <= (state == ST_CS_HOLD) ? hold_cnt + 8'd1 : 8'd0;

         if (state == ST_DATA && rise_en) rx_sr <= {rx_sr[5:0], spi_miso};

         if (state == ST_DATA && rise_en && bit_cnt == 6'd7) begin
            rd_data  <= {rx_sr, spi_miso};
            rd_valid <= 1'b1;
         end else if (rd_ready) begin
            rd_valid <= 1'b0;
         end
      end
   end

   assign done = done_pulse;

endmodule

`default_nettype wire

// File: tb/tb_spi_flash_burst_reader.sv
// +--------------------------------------------------------------------------+
// | tb_spi_flash_burst_reader : randomized bench with a behavioural flash     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_spi_flash_burst_reader;

   localparam int CLK_DIV   = 2;
   localparam int BUDGET    = 6000;
`ifdef FAST_READ_EN
   localparam int         HDR_BITS = 40;
   localparam logic [7:0] EXP_OP   = 8'h0B;
`else
   localparam int         HDR_BITS = 32;
   localparam logic [7:0] EXP_OP   = 8'h03;
`endif
   localparam logic [31:0] FLASH_MASK = 32'h003F_FFFF;

   logic        clk        = 1'b0;
   logic        reset      = 1'b0;
   logic        start      = 1'b0;
   logic [23:0] start_addr = '0;
   logic [15:0] byte_count = '0;
   logic        rd_ready   = 1'b0;
   logic        spi_miso   = 1'b0;
   logic        busy, done, rd_valid, spi_cs_n, spi_sck, spi_mosi;
   logic [7:0]  rd_data;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   spi_flash_burst_reader #(
      .CLK_DIV   (CLK_DIV),
      .ADDR_BITS (24),
      .LEN_BITS  (16),
      .CMD_READ  (8'h03),
      .CMD_FAST  (8'h0B)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .start_addr (start_addr),
      .byte_count (byte_count),
      .busy       (busy),
      .done       (done),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .rd_ready   (rd_ready),
      .spi_cs_n   (spi_cs_n),
      .spi_sck    (spi_sck),
      .spi_mosi   (spi_mosi),
      .spi_miso   (spi_miso)
   );

   // 32 Mbit flash image: mem[i] = i[7:0] ^ 8'hA5, addresses wrap at 4 MiB.
   function automatic logic [7:0] flash_byte(input logic [31:0] a);
      logic [31:0] m;
      m = a & FLASH_MASK;
      return m[7:0] ^ 8'hA5;
   endfunction

   int          fl_rises = 0;
   logic [31:0] fl_hdr   = '0;

   always @(posedge spi_sck or posedge spi_cs_n) begin
      if (spi_cs_n) begin
         fl_rises <= 0;
      end else begin
         if (fl_rises < 32) fl_hdr <= {fl_hdr[30:0], spi_mosi};
         fl_rises <= fl_rises + 1;
      end
   end

   always @(negedge spi_sck) begin
      int          d;
      logic [7:0]  b;
      if (!spi_cs_n && fl_rises >= HDR_BITS) begin
         d = fl_rises - HDR_BITS;
         b = flash_byte({8'h00, fl_hdr[23:0]} + 32'(d / 8));
         spi_miso <= b[7 - (d % 8)];
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // rmode: 0 = always ready, 1 = random ready, 2 = stall 200 cycles after first valid
   task automatic run_burst(input logic [23:0] addr, input int count, input int rmode,
                            input bit spurious, input string tag);
      logic [7:0] got_q[$];
      int         cyc, rises, dones, done_cyc, first_valid, freeze_bad;
      bit         prev_sck;
      @(negedge clk);
      start      = 1'b1;
      start_addr = addr;
      byte_count = 16'(count);
      rd_ready   = (rmode != 1);
      @(negedge clk);
      start = 1'b0;
      check({tag, " busy_after_accept"}, busy, 1);
      cyc = 1; rises = 0; dones = 0; done_cyc = -1; first_valid = -1; freeze_bad = 0;
      prev_sck = spi_sck;
      while (cyc < BUDGET && !(done_cyc >= 0 && cyc > done_cyc + 4)) begin
         if (done) begin
            dones++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (spi_sck && !prev_sck) rises++;
         prev_sck = spi_sck;
         if (rd_valid && first_valid < 0) first_valid = cyc;
         case (rmode)
            1:       rd_ready = 1'($urandom_range(0, 1));
            2:       rd_ready = !(first_valid >= 0 && cyc < first_valid + 200);
            default: rd_ready = 1'b1;
         endcase
         if (rmode == 2 && first_valid >= 0 && cyc > first_valid + CLK_DIV + 1 &&
             cyc < first_valid + 200 && (spi_sck || spi_cs_n))
            freeze_bad++;
         if (spurious && cyc == 20) begin
            start      = 1'b1;
            start_addr = addr ^ 24'h5A5A5A;
            byte_count = 16'(count + 5);
         end else begin
            start = 1'b0;
         end
         if (rd_valid && rd_ready) got_q.push_back(rd_data);
         @(negedge clk);
         cyc++;
      end
      rd_ready = 1'b1;
      check({tag, " done_seen"}, done_cyc >= 0, 1);
      check({tag, " done_pulses"}, dones, 1);
      check({tag, " byte_total"}, got_q.size(), count);
      check({tag, " cs_released"}, spi_cs_n, 1);
      check({tag, " busy_cleared"}, busy, 0);
      if (count == 0) begin
         check({tag, " done_latency"}, done_cyc, 2);
         check({tag, " no_sck"}, rises, 0);
         check({tag, " no_valid"}, first_valid < 0, 1);
      end else begin
         check({tag, " sck_rises"}, rises, HDR_BITS + 8 * count);
         check({tag, " opcode"}, fl_hdr[31:24], EXP_OP);
         check({tag, " address"}, fl_hdr[23:0], addr);
      end
      if (rmode == 2) check({tag, " sck_frozen"}, freeze_bad, 0);
      for (int i = 0; i < got_q.size() && i < count; i++)
         check($sformatf("%s byte%0d", tag, i), got_q[i], flash_byte({8'h00, addr} + 32'(i)));
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("reset cs_n", spi_cs_n, 1);
      check("reset sck", spi_sck, 0);
      check("reset mosi", spi_mosi, 0);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset rd_valid", rd_valid, 0);
      check("reset rd_data", rd_data, 0);
      reset = 1'b1;
      rd_ready = 1'b1;

      run_burst(24'h000010, 4, 0, 1'b0, "basic");
      run_burst(24'h123456, 0, 0, 1'b0, "zero_len");
      run_burst(24'h000200, 3, 2, 1'b0, "backpressure");

      // Abort in the middle of the address phase.
      @(negedge clk);
      start = 1'b1; start_addr = 24'h0F0F00; byte_count = 16'd4; rd_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (60) @(negedge clk);
      check("abort cs_active", spi_cs_n, 0);
      reset = 1'b0;
      #1;
      check("abort cs_n", spi_cs_n, 1);
      check("abort sck", spi_sck, 0);
      check("abort busy", busy, 0);
      check("abort done", done, 0);
      @(negedge clk);
      reset = 1'b1;
      run_burst(24'h0ABCDE, 3, 0, 1'b0, "after_reset");

      run_burst(24'h000040, 3, 0, 1'b1, "ignored_start");
      run_burst(24'h3FFFFE, 3, 1, 1'b0, "wrap");
      for (int k = 0; k < 6; k++)
         run_burst(24'($urandom), int'($urandom_range(0, 6)), 1, 1'b0, $sformatf("rand%0d", k));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
